imem_arbiter: RTL
=================

Name: imem_arbiter

Overview:
- Shares the single instruction-memory port between two requesters:
  - the CPU fetch path (read-only, driven from the program counter);
  - a program loader (write-only, fills imem after reset or on reload).
- Sits between the CPU top-level and the imem macro.
- Owns the memory request/acknowledge handshake.
- Loader has fixed priority, with a starvation bound that guarantees fetch progress.

Parameters:
- ADDR_W, 32, width of address buses.
- DATA_W, 32, width of data buses.
- MAX_STARVE, 4, consecutive loader grants allowed while fetch is pending before fetch is forced a grant (≥1).
- TIMEOUT, 16, cycles in BUSY without i_memAck before abort; used only with the optional feature.

Ports:
- i_clock  in  1  clock
- i_resetn  in  1  asynchronous active-low reset
- i_fetchReq  in  1  fetch request, held with address until o_fetchAck
- i_fetchAddr  in  ADDR_W  fetch address
- o_fetchAck  out  1  one-cycle pulse; o_fetchData valid in same cycle
- o_fetchData  out  DATA_W  registered read data
- i_loadReq  in  1  loader write request, held until o_loadAck
- i_loadAddr  in  ADDR_W  write address
- i_loadData  in  DATA_W  write data
- o_loadAck  out  1  one-cycle pulse on write completion
- o_memReq  out  1  memory request, high until i_memAck
- o_memWe  out  1  1 = write (loader), 0 = read (fetch)
- o_memAddr  out  ADDR_W  registered address
- o_memWdata  out  DATA_W  registered write data
- i_memAck  in  1  memory completion, sampled while o_memReq = 1
- i_memRdata  in  DATA_W  read data, valid when i_memAck = 1
- o_error  out  1  one-cycle pulse with the ack of an aborted transaction

Behaviour:
- Clock and reset:
  - One clock, i_clock.
  - Reset i_resetn is asynchronous, active-low.
  - Reset values: state IDLE; all outputs 0, including o_fetchData, o_memAddr and o_memWdata; starve counter 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Arbitrates on the current-cycle request lines.
  - Loader only: grant loader.
  - Fetch only: grant fetch.
  - Both requesting: grant fetch if starveCnt == MAX_STARVE, else grant loader.
  - On grant, at the next edge: go to BUSY; register the winner's address and data into o_memAddr / o_memWdata; set o_memWe; set o_memReq = 1; latch owner.
- BUSY:
  - o_memReq stays 1; address and data stay stable.
  - When i_memAck = 1: drop o_memReq; for a read, capture i_memRdata into o_fetchData; go to RESP.
- RESP:
  - Owner's ack = 1 for exactly one cycle; next state is IDLE.
  - Requests seen in BUSY or RESP are ignored; only a request seen in IDLE starts a transaction.
  - A requester must deassert or update its request in the cycle after its ack.
- Latency: fetch request in cycle 0 with zero-wait memory (ack in cycle 1) gives o_memReq in cycle 1, o_fetchAck in cycle 2, IDLE in cycle 3. Back-to-back transactions occur at most once every 3 cycles.
- Starve counter:
  - Increments on each loader grant made while i_fetchReq = 1, saturating at MAX_STARVE.
  - Clears to 0 on any fetch grant.
  - Unchanged on a loader grant with no fetch pending.
- Width: counter is $clog2(MAX_STARVE+1) bits; no address arithmetic in this block.
- o_fetchData holds its last value between reads.
- Reset mid-transaction: immediate IDLE; o_memReq drops asynchronously; no ack is issued; a late i_memAck in IDLE is ignored.
- A simultaneous i_memAck and reset deassertion edge is ignored.

Optional Feature:
- Macro: IMEM_ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in BUSY.
  - After TIMEOUT cycles with no i_memAck: drop o_memReq and go to RESP, pulsing the owner's ack together with o_error = 1.
  - An aborted fetch returns o_fetchData = 32'h00000013 (RISC-V NOP).
  - A late i_memAck is ignored.
- When undefined:
  - BUSY waits indefinitely.
  - o_error is tied 0; the port remains present.

Decomposition:
- Package imem_arb_pkg contains:
  - state enum (IDLE, BUSY, RESP);
  - owner enum (OWN_FETCH, OWN_LOAD);
  - NOP_INSTR constant 32'h00000013.
- Sub-module imem_arb_starve_cnt: saturating counter with inc / clr / full.
- The FSM and datapath registers stay in imem_arbiter.

Test Plan:
- Fetch only, addr 0x00000004, memory acks in 1st BUSY cycle with 0x00500093 -> o_memReq cycle 1 with o_memWe = 0; o_fetchAck and o_fetchData = 0x00500093 in cycle 2; IDLE in cycle 3.
- Loader writes 0x00A00113 to 0x00000008, 3-cycle memory wait -> o_memWe = 1, address and data stable for all 3 BUSY cycles; o_loadAck pulse once; o_fetchAck stays 0.
- Both held continuously, MAX_STARVE = 4 -> grant sequence L, L, L, L, F, L, L, L, L, F.
- Reset asserted in the 2nd BUSY cycle of a fetch -> o_memReq 0 immediately; no o_fetchAck; a later i_memAck in IDLE produces nothing.
- With IMEM_ARB_TIMEOUT_EN and TIMEOUT = 16, memory never acks a fetch -> after 16 BUSY cycles, o_fetchAck = 1, o_error = 1, o_fetchData = 0x00000013.
- Request held high through RESP -> exactly one new transaction begins from IDLE; no duplicate ack.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_LOAD
  } owner_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/imem_arb_starve_cnt.sv
// Saturating counter of loader grants won while fetch was waiting; full forces a fetch grant.
module imem_arb_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic full
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !full) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign full = (cnt == W'(MAX));

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single imem port between CPU fetch (read) and program loader (write).
// IMEM_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts with o_error and a NOP for fetches.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              i_clock,
  input  logic              i_resetn,
  input  logic              i_fetchReq,
  input  logic [ADDR_W-1:0] i_fetchAddr,
  output logic              o_fetchAck,
  output logic [DATA_W-1:0] o_fetchData,
  input  logic              i_loadReq,
  input  logic [ADDR_W-1:0] i_loadAddr,
  input  logic [DATA_W-1:0] i_loadData,
  output logic              o_loadAck,
  output logic              o_memReq,
  output logic              o_memWe,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [DATA_W-1:0] o_memWdata,
  input  logic              i_memAck,
  input  logic [DATA_W-1:0] i_memRdata,
  output logic              o_error
);

  state_t state, next_state;
  owner_t owner;
  logic   starve_full;
  logic   grant_fetch;
  logic   grant_load;
  logic   timeout;

  // Fetch wins only when alone or when the loader has used up its starvation allowance.
  assign grant_fetch = (state == IDLE) && i_fetchReq && (!i_loadReq || starve_full);
  assign grant_load  = (state == IDLE) && i_loadReq && !grant_fetch;

  imem_arb_starve_cnt #(
    .MAX (MAX_STARVE)
  ) u_starve_cnt (
    .clk   (i_clock),
    .rst_n (i_resetn),
    .inc   (grant_load && i_fetchReq),
    .clr   (grant_fetch),
    .full  (starve_full)
  );

`ifdef IMEM_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] busy_cnt;
  logic            abort_q;

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      busy_cnt <= '0;
    end else if (state == BUSY) begin
      busy_cnt <= busy_cnt + 1'b1;
    end else begin
      busy_cnt <= '0;
    end
  end

  // A real ack in the final watchdog cycle still completes normally.
  assign timeout = (state == BUSY) && !i_memAck && (busy_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      abort_q <= 1'b0;
    end else if (state == BUSY) begin
      abort_q <= timeout;
    end
  end

  assign o_error = (state == RESP) && abort_q;
`else
  // Constant 0; referencing TIMEOUT keeps the parameter live in builds without the watchdog.
  assign timeout = (TIMEOUT < 0);
  assign o_error = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_fetch || grant_load) next_state = BUSY;
      BUSY:    if (i_memAck || timeout) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      o_memReq    <= 1'b0;
      o_memWe     <= 1'b0;
      o_memAddr   <= '0;
      o_memWdata  <= '0;
      o_fetchData <= '0;
      owner       <= OWN_FETCH;
    end else if (grant_fetch || grant_load) begin
      o_memReq  <= 1'b1;
      o_memWe   <= grant_load;
      o_memAddr <= grant_load ? i_loadAddr : i_fetchAddr;
      owner     <= grant_load ? OWN_LOAD : OWN_FETCH;
      if (grant_load) begin
        o_memWdata <= i_loadData;
      end
    end else if ((state == BUSY) && i_memAck) begin
      o_memReq <= 1'b0;
      if (owner == OWN_FETCH) begin
        o_fetchData <= i_memRdata;
      end
    end else if (timeout) begin
      o_memReq <= 1'b0;
      if (owner == OWN_FETCH) begin
        o_fetchData <= DATA_W'(NOP_INSTR);
      end
    end
  end

  assign o_fetchAck = (state == RESP) && (owner == OWN_FETCH);
  assign o_loadAck  = (state == RESP) && (owner == OWN_LOAD);

endmodule
